wide_word_serializer: RTL and testbench

- Sequencing controller that snapshots a 4096-bit vector (128 x 32-bit words) and streams a window of words out one per handshake over a valid/ready port.
- Drives a 7-bit word select internally, with wrap-around from index 127 to 0.
- Sits between wide register-file/LSU result buses and narrow 32-bit consumers: debug readout, FPGA host bridge, scalar writeback.

---
 rtl/wide_word_serializer_pkg.sv | 21 ++
 rtl/wide_word_serializer.sv | 113 +++++++++++
 tb/tb_wide_word_serializer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wide_word_serializer_pkg.sv
// rtl/wide_word_serializer_pkg.sv - shared constants, state encoding and count clamp for the serializer
package wide_word_serializer_pkg;

  localparam int NUM_WORDS = 128;
  localparam int WORD_W    = 32;
  localparam int IDX_W     = 7;
  localparam int CNT_W     = 8;
  localparam int VEC_W     = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    WWS_IDLE   = 2'd0,
    WWS_STREAM = 2'd1,
    WWS_FIN    = 2'd2
  } wws_state_t;

  // Requests beyond the vector size collapse to one full pass.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
    return (count > CNT_W'(NUM_WORDS)) ? CNT_W'(NUM_WORDS) : count;
  endfunction

endpackage

// File: rtl/wide_word_serializer.sv
// rtl/wide_word_serializer.sv - snapshots a 128x32 vector and streams a wrapping word window over valid/ready
// Optional per-word skip mask enabled by WIDE_WORD_SERIALIZER_MASK_EN.
module wide_word_serializer
  import wide_word_serializer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     start_idx,
  input  logic [CNT_W-1:0]     word_count,
  input  logic [VEC_W-1:0]     data_in,
`ifdef WIDE_WORD_SERIALIZER_MASK_EN
  input  logic [NUM_WORDS-1:0] mask_in,
`endif
  input  logic                 flush,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 done
);

  wws_state_t       state;
  wws_state_t       state_nxt;
  logic [VEC_W-1:0] snap;
  logic [IDX_W-1:0] cur_idx;
  logic [CNT_W-1:0] remaining;
  logic             cur_en;
  logic             accept;
  logic             advance;

`ifdef WIDE_WORD_SERIALIZER_MASK_EN
  logic [NUM_WORDS-1:0] mask_q;
  assign cur_en = mask_q[cur_idx];
`else
  assign cur_en = 1'b1;
`endif

  assign accept = (state == WWS_IDLE) && start && !flush;
  // A masked index retires on its own each cycle; an enabled one waits for the consumer.
  assign advance = (state == WWS_STREAM) && !flush && (cur_en ? out_ready : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WWS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WWS_IDLE: begin
        if (accept) begin
          state_nxt = (clamp_count(word_count) == '0) ? WWS_FIN : WWS_STREAM;
        end
      end
      WWS_STREAM: begin
        if (flush) begin
          state_nxt = WWS_IDLE;
        end else if (advance && (remaining == CNT_W'(1))) begin
          state_nxt = WWS_FIN;
        end
      end
      WWS_FIN:  state_nxt = WWS_IDLE;
      default:  state_nxt = WWS_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != WWS_IDLE);
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      WWS_STREAM: begin
        out_valid = cur_en;
        out_last  = cur_en && (remaining == CNT_W'(1));
      end
      WWS_FIN:  done = !flush;
      default:  ;
    endcase
  end

  // Word select straight off the snapshot; zero after reset since both snap and cur_idx clear.
  assign out_data = snap[{cur_idx, 5'b0} +: WORD_W];
  assign out_idx  = cur_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      cur_idx   <= '0;
      remaining <= '0;
`ifdef WIDE_WORD_SERIALIZER_MASK_EN
      mask_q    <= '0;
`endif
    end else if (accept) begin
      snap      <= data_in;
      cur_idx   <= start_idx;
      remaining <= clamp_count(word_count);
`ifdef WIDE_WORD_SERIALIZER_MASK_EN
      mask_q    <= mask_in;
`endif
    end else if (advance) begin
      cur_idx   <= cur_idx + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_wide_word_serializer.sv
// tb/tb_wide_word_serializer.sv - randomized bench against a queue-based window model of the serializer
// Covers the WIDE_WORD_SERIALIZER_MASK_EN build when that macro is defined.
module tb_wide_word_serializer;
  import wide_word_serializer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [6:0]     start_idx;
  logic [7:0]     word_count;
  logic [4095:0]  data_in;
  logic [127:0]   mask_v;
  logic           flush;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_data;
  logic [6:0]     out_idx;
  logic           out_last;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] expq[$];

  always #5 clk = ~clk;

  wide_word_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_idx  (start_idx),
    .word_count (word_count),
    .data_in    (data_in),
`ifdef WIDE_WORD_SERIALIZER_MASK_EN
    .mask_in    (mask_v),
`endif
    .flush      (flush),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_data(input bit pattern);
    for (int i = 0; i < 128; i++) begin
      data_in[i*32 +: 32] = pattern ? (32'hA000_0000 + i) : $urandom;
    end
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return ((c % 4) == 0) || ((c % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Expected beats: the clamped window of indices, modulo 128, minus masked ones.
  task automatic build_model(input int s, input int cnt);
    int n;
    int idx;
    expq.delete();
    n = (cnt > 128) ? 128 : cnt;
    for (int k = 0; k < n; k++) begin
      idx = (s + k) % 128;
      if (mask_v[idx]) begin
        expq.push_back({(k == n - 1), 7'(idx), data_in[idx*32 +: 32]});
      end
    end
  endtask

  task automatic run(input int s, input int cnt, input int rmode, input bit disturb);
    bit          seen_done;
    bit          prev_v;
    bit          prev_r;
    bit          prev_last_beat;
    bit          want_last;
    logic [39:0] prev_out;
    int          n;
    n = (cnt > 128) ? 128 : cnt;
    build_model(s, cnt);
    want_last = (expq.size() > 0) && expq[expq.size()-1][39];
    seen_done = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_last_beat = 1'b0;
    prev_out = '0;
    @(posedge clk); #1;
    start = 1'b1; start_idx = s[6:0]; word_count = cnt[7:0];
    out_ready = pick_ready(rmode, 0);
    @(posedge clk); #1;
    if (disturb) begin
      fill_data(1'b0);
      start_idx = start_idx + 7'd33;
      word_count = 8'd7;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      @(negedge clk);
      if (prev_v && !prev_r) begin
        check("stall_hold", {out_valid, out_last, out_idx, out_data}, {1'b1, prev_out});
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("extra_beat", {out_idx, out_data}, '0);
        end else begin
          check("beat", {out_last, out_idx, out_data}, expq[0]);
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_queue_empty", expq.size(), 0);
        if (n == 0) check("zero_count_done_latency", cyc, 0);
        else if (want_last) check("done_after_last", prev_last_beat, 1);
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_out = {out_last, out_idx, out_data};
      prev_last_beat = out_valid && out_ready && out_last;
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = pick_ready(rmode, cyc + 1);
    end
    check("done_seen", seen_done, 1);
    @(negedge clk);
    check("idle_after_done", {done, busy, out_valid}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_idx = '0; word_count = '0;
    flush = 1'b0; out_ready = 1'b0; mask_v = '1;
    fill_data(1'b1);
    #12;
    check("reset_outputs", {busy, out_valid, out_last, done, out_idx, out_data}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", {busy, out_valid, done}, '0);

    run(5, 3, 0, 1'b0);
    run(126, 4, 0, 1'b0);
    run(64, 128, 0, 1'b0);
    run(20, 9, 1, 1'b0);
    run(100, 40, 2, 1'b1);
    run(3, 200, 2, 1'b0);
    run(77, 0, 0, 1'b1);
    run(9, 1, 1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int cnt;
      case ($urandom_range(0, 4))
        0: cnt = 0;
        1: cnt = 1;
        2: cnt = 128;
        3: cnt = $urandom_range(129, 255);
        default: cnt = $urandom_range(2, 127);
      endcase
      fill_data(1'b0);
`ifdef WIDE_WORD_SERIALIZER_MASK_EN
      mask_v = {$urandom, $urandom, $urandom, $urandom};
`endif
      run($urandom_range(0, 127), cnt, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef WIDE_WORD_SERIALIZER_MASK_EN
    fill_data(1'b1);
    mask_v = 128'h5;
    run(0, 4, 0, 1'b0);
    mask_v = '0;
    run(10, 6, 2, 1'b0);
    mask_v = '1;
`endif

    // Flush after two of ten beats: no done, idle next cycle.
    fill_data(1'b1);
    @(posedge clk); #1 start = 1'b1; start_idx = 7'd30; word_count = 8'd10; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); check("flush_beat0", {out_valid, out_idx}, {1'b1, 7'd30});
    @(posedge clk); #1;
    @(negedge clk); check("flush_beat1", {out_valid, out_idx}, {1'b1, 7'd31});
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk); check("flush_cycle", {out_valid, done}, {1'b1, 1'b0});
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); check("after_flush", {busy, out_valid, done}, '0);
    @(negedge clk); check("no_done_after_flush", {busy, done}, '0);

    // Flush outranks start in IDLE.
    @(posedge clk); #1 start = 1'b1; flush = 1'b1; word_count = 8'd4;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk); check("flush_beats_start", {busy, out_valid}, '0);

    // Asynchronous reset mid-stream clears outputs without waiting for a clock.
    @(posedge clk); #1 start = 1'b1; start_idx = 7'd10; word_count = 8'd20; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); check("pre_reset_valid", {busy, out_valid, out_idx}, {2'b11, 7'd10});
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {busy, out_valid, out_last, done, out_idx, out_data}, '0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", {busy, out_valid, done}, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
